// File: rtl/issue_ex_pipe_reg.sv
// rtl/issue_ex_pipe_reg.sv - issue-to-EX pipeline register with load-use scoreboard
// Holds the issued bundle, patches operands from forwarding while held, and interlocks on in-flight loads.
module issue_ex_pipe_reg #(
  parameter int LANES    = 2,
  parameter int XLEN     = 32,
  parameter int PW       = 160,
  parameter int LOAD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES-1:0]      in_lane_vld,
  input  logic [LANES*PW-1:0]   in_payload,
  input  logic [LANES*5-1:0]    in_rj,
  input  logic [LANES*5-1:0]    in_rk,
  input  logic [LANES*5-1:0]    in_rd,
  input  logic [LANES-1:0]      in_we,
  input  logic [LANES-1:0]      in_is_load,
  input  logic [LANES*XLEN-1:0] rf_rj_data,
  input  logic [LANES*XLEN-1:0] rf_rk_data,
  input  logic [LANES-1:0]      fwd_j_vld,
  input  logic [LANES-1:0]      fwd_k_vld,
  input  logic [LANES*XLEN-1:0] fwd_j_data,
  input  logic [LANES*XLEN-1:0] fwd_k_data,
  input  logic                  fwd_stall,
  input  logic                  ex_ready,
  output logic                  out_valid,
  output logic [LANES-1:0]      out_lane_vld,
  output logic [LANES*PW-1:0]   out_payload,
  output logic [LANES*XLEN-1:0] out_rj_data,
  output logic [LANES*XLEN-1:0] out_rk_data,
  output logic [LANES*5-1:0]    out_rd,
  output logic [LANES-1:0]      out_we,
  output logic [LANES-1:0]      out_is_load,
  output logic                  hazard_stall
);

  logic                  valid_q, valid_d;
  logic [LANES-1:0]      lane_vld_q, lane_vld_d;
  logic [LANES*PW-1:0]   payload_q, payload_d;
  logic [LANES*XLEN-1:0] rj_data_q, rj_data_d;
  logic [LANES*XLEN-1:0] rk_data_q, rk_data_d;
  logic [LANES*5-1:0]    rd_q, rd_d;
  logic [LANES-1:0]      we_q, we_d;
  logic [LANES-1:0]      is_load_q, is_load_d;

  logic [LOAD_LAT-1:0][LANES-1:0]   sb_vld_q, sb_vld_d;
  logic [LOAD_LAT-1:0][LANES*5-1:0] sb_rd_q, sb_rd_d;

  logic             adv;
  logic             accept;
  logic             hazard;
  logic [LANES-1:0] stage_ld;

  // Advance is decoupled from out_valid so bubbles drain instead of deadlocking.
  assign adv      = ex_ready & ~fwd_stall;
  assign stage_ld = {LANES{valid_q}} & lane_vld_q & is_load_q & we_q;
  assign in_ready = adv & ~hazard & ~flush;
  assign accept   = in_valid & in_ready;

  function automatic logic src_busy(input logic [4:0] src);
    src_busy = 1'b0;
    if (src != 5'd0) begin
      for (int m = 0; m < LANES; m++) begin
        if (stage_ld[m] && (rd_q[m*5 +: 5] == src)) src_busy = 1'b1;
        for (int r = 0; r < LOAD_LAT; r++) begin
          if (sb_vld_q[r][m] && (sb_rd_q[r][m*5 +: 5] == src)) src_busy = 1'b1;
        end
      end
    end
  endfunction

  always_comb begin
    hazard = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (in_valid && in_lane_vld[l]) begin
        if (src_busy(in_rj[l*5 +: 5]) || src_busy(in_rk[l*5 +: 5])) hazard = 1'b1;
      end
    end
  end

  assign hazard_stall = hazard;

  always_comb begin
    valid_d   = valid_q;
    lane_vld_d = lane_vld_q;
    payload_d = payload_q;
    rj_data_d = rj_data_q;
    rk_data_d = rk_data_q;
    rd_d      = rd_q;
    we_d      = we_q;
    is_load_d = is_load_q;
    if (flush) begin
      valid_d    = 1'b0;
      lane_vld_d = '0;
    end else if (accept) begin
      valid_d    = 1'b1;
      lane_vld_d = in_lane_vld;
      payload_d  = in_payload;
      rj_data_d  = rf_rj_data;
      rk_data_d  = rf_rk_data;
      rd_d       = in_rd;
      we_d       = in_we;
      is_load_d  = in_is_load;
    end else if (adv) begin
      valid_d    = 1'b0;
      lane_vld_d = '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (fwd_j_vld[l]) rj_data_d[l*XLEN +: XLEN] = fwd_j_data[l*XLEN +: XLEN];
        if (fwd_k_vld[l]) rk_data_d[l*XLEN +: XLEN] = fwd_k_data[l*XLEN +: XLEN];
      end
    end
  end

  // Flushed loads are older than the flush and stay tracked; only advance shifts the scoreboard.
  always_comb begin
    sb_vld_d = sb_vld_q;
    sb_rd_d  = sb_rd_q;
    if (adv) begin
      for (int r = 1; r < LOAD_LAT; r++) begin
        sb_vld_d[r] = sb_vld_q[r-1];
        sb_rd_d[r]  = sb_rd_q[r-1];
      end
      for (int m = 0; m < LANES; m++) begin
        sb_vld_d[0][m] = stage_ld[m] & (rd_q[m*5 +: 5] != 5'd0);
      end
      sb_rd_d[0] = rd_q;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      valid_q    <= 1'b0;
      lane_vld_q <= '0;
      payload_q  <= '0;
      rj_data_q  <= '0;
      rk_data_q  <= '0;
      rd_q       <= '0;
      we_q       <= '0;
      is_load_q  <= '0;
      sb_vld_q   <= '0;
      sb_rd_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      lane_vld_q <= lane_vld_d;
      payload_q  <= payload_d;
      rj_data_q  <= rj_data_d;
      rk_data_q  <= rk_data_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      is_load_q  <= is_load_d;
      sb_vld_q   <= sb_vld_d;
      sb_rd_q    <= sb_rd_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_lane_vld = lane_vld_q;
  assign out_payload  = payload_q;
  assign out_rj_data  = rj_data_q;
  assign out_rk_data  = rk_data_q;
  assign out_rd       = rd_q;
  assign out_we       = we_q;
  assign out_is_load  = is_load_q;

endmodule

// File: tb/tb_issue_ex_pipe_reg.sv
// tb/tb_issue_ex_pipe_reg.sv - self-checking bench for issue_ex_pipe_reg
// Hazard vector table, directed corner sequences and random traffic against a register-set reference model.
module tb_issue_ex_pipe_reg;
  localparam int LANES = 2, XLEN = 32, PW = 160, LOAD_LAT = 2;

  logic clk = 1'b0;
  logic clk_run = 1'b1;
  logic areset, flush, in_valid, in_ready, fwd_stall, ex_ready, out_valid, hazard_stall;
  logic [LANES-1:0]      in_lane_vld, in_we, in_is_load, fwd_j_vld, fwd_k_vld;
  logic [LANES*PW-1:0]   in_payload, out_payload;
  logic [LANES*5-1:0]    in_rj, in_rk, in_rd, out_rd;
  logic [LANES*XLEN-1:0] rf_rj_data, rf_rk_data, fwd_j_data, fwd_k_data, out_rj_data, out_rk_data;
  logic [LANES-1:0]      out_lane_vld, out_we, out_is_load;

  int n_cmp = 0;
  int n_bad = 0;

  issue_ex_pipe_reg #(.LANES(LANES), .XLEN(XLEN), .PW(PW), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .areset(areset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_vld(in_lane_vld), .in_payload(in_payload), .in_rj(in_rj), .in_rk(in_rk),
    .in_rd(in_rd), .in_we(in_we), .in_is_load(in_is_load), .rf_rj_data(rf_rj_data),
    .rf_rk_data(rf_rk_data), .fwd_j_vld(fwd_j_vld), .fwd_k_vld(fwd_k_vld),
    .fwd_j_data(fwd_j_data), .fwd_k_data(fwd_k_data), .fwd_stall(fwd_stall),
    .ex_ready(ex_ready), .out_valid(out_valid), .out_lane_vld(out_lane_vld),
    .out_payload(out_payload), .out_rj_data(out_rj_data), .out_rk_data(out_rk_data),
    .out_rd(out_rd), .out_we(out_we), .out_is_load(out_is_load), .hazard_stall(hazard_stall)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // Reference model: stage contents plus a queue of per-advance sets of busy load destinations.
  logic                  m_valid;
  logic [LANES-1:0]      m_lv, m_we, m_ld;
  logic [LANES*PW-1:0]   m_pl;
  logic [LANES*XLEN-1:0] m_rj, m_rk;
  logic [LANES*5-1:0]    m_rd;
  logic [31:0]           m_sb[$];

  task automatic model_reset();
    m_valid = 1'b0; m_lv = '0; m_we = '0; m_ld = '0;
    m_pl = '0; m_rj = '0; m_rk = '0; m_rd = '0;
    m_sb = {};
    repeat (LOAD_LAT) m_sb.push_back(32'd0);
  endtask

  function automatic logic [31:0] stage_loads();
    logic [31:0] mask = '0;
    for (int l = 0; l < LANES; l++)
      if (m_valid && m_lv[l] && m_ld[l] && m_we[l]) mask[m_rd[l*5 +: 5]] = 1'b1;
    mask[0] = 1'b0;
    return mask;
  endfunction

  function automatic logic m_hazard();
    logic [31:0] busy = stage_loads();
    foreach (m_sb[i]) busy |= m_sb[i];
    busy[0] = 1'b0;
    for (int l = 0; l < LANES; l++)
      if (in_valid && in_lane_vld[l] && (busy[in_rj[l*5 +: 5]] || busy[in_rk[l*5 +: 5]])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_ready();
    return ex_ready && !fwd_stall && !flush && !m_hazard();
  endfunction

  task automatic model_update();
    logic adv = ex_ready && !fwd_stall;
    logic acc = in_valid && m_ready();
    if (adv) begin
      m_sb.push_front(stage_loads());
      void'(m_sb.pop_back());
    end
    if (flush) begin
      m_valid = 1'b0; m_lv = '0;
    end else if (acc) begin
      m_valid = 1'b1; m_lv = in_lane_vld; m_pl = in_payload; m_rj = rf_rj_data;
      m_rk = rf_rk_data; m_rd = in_rd; m_we = in_we; m_ld = in_is_load;
    end else if (adv) begin
      m_valid = 1'b0; m_lv = '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (fwd_j_vld[l]) m_rj[l*XLEN +: XLEN] = fwd_j_data[l*XLEN +: XLEN];
        if (fwd_k_vld[l]) m_rk[l*XLEN +: XLEN] = fwd_k_data[l*XLEN +: XLEN];
      end
    end
  endtask

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_comb();
    chk("hazard_stall", hazard_stall, m_hazard());
    chk("in_ready", in_ready, m_ready());
  endtask

  task automatic check_regs();
    chk("out_valid", out_valid, m_valid);
    chk("out_lane_vld", out_lane_vld, m_lv);
    chk("out_payload", out_payload, m_pl);
    chk("out_rj_data", out_rj_data, m_rj);
    chk("out_rk_data", out_rk_data, m_rk);
    chk("out_rd", out_rd, m_rd);
    chk("out_we", out_we, m_we);
    chk("out_is_load", out_is_load, m_ld);
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic cycle();
    #1;
    check_comb();
    model_update();
    @(posedge clk);
    @(negedge clk);
    check_regs();
  endtask

  task automatic idle(input logic exr);
    in_valid = 1'b0; flush = 1'b0; ex_ready = exr; fwd_stall = 1'b0;
    in_lane_vld = '0; in_rj = '0; in_rk = '0; in_rd = '0; in_we = '0; in_is_load = '0;
    fwd_j_vld = '0; fwd_k_vld = '0; fwd_j_data = '0; fwd_k_data = '0;
    in_payload = '0; rf_rj_data = '0; rf_rk_data = '0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < LANES*PW/32; i++) in_payload[i*32 +: 32] = $urandom;
    for (int i = 0; i < LANES; i++) begin
      rf_rj_data[i*XLEN +: XLEN] = $urandom; rf_rk_data[i*XLEN +: XLEN] = $urandom;
      fwd_j_data[i*XLEN +: XLEN] = $urandom; fwd_k_data[i*XLEN +: XLEN] = $urandom;
    end
  endtask

  task automatic set_bundle(input logic [1:0] lv, input logic [4:0] rj0, rk0, rd0, rj1, rk1, rd1,
                            input logic [1:0] we, ld);
    in_valid = 1'b1; in_lane_vld = lv;
    in_rj = {rj1, rj0}; in_rk = {rk1, rk0}; in_rd = {rd1, rd0};
    in_we = we; in_is_load = ld;
    rand_data();
  endtask

  typedef struct {
    logic       iv;
    logic [1:0] lv;
    logic [4:0] rj0, rk0, rj1, rk1;
    logic       fl, exr, fst;
    logic       haz, rdy;
  } vec_t;

  vec_t tbl[11];
  int   stalls;
  logic accepted;

  initial begin
    // State for the table: stage holds lane0 load r7 + lane1 ALU r3, scoreboard row0 holds load r9.
    tbl[0]  = '{1'b0, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 2'b11, 5'd0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 2'b11, 5'd0, 5'd9, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 2'b11, 5'd3, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 2'b01, 5'd0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 2'b10, 5'd0, 5'd0, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 2'b11, 5'd4, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 2'b11, 5'd4, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 2'b11, 5'd4, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 2'b11, 5'd7, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    areset = 1'b1;
    idle(1'b1);
    model_reset();
    repeat (2) @(negedge clk);
    check_regs();
    areset = 1'b0;

    set_bundle(2'b01, 5'd1, 5'd2, 5'd9, 5'd0, 5'd0, 5'd0, 2'b01, 2'b01);
    cycle();
    set_bundle(2'b11, 5'd1, 5'd2, 5'd7, 5'd1, 5'd2, 5'd3, 2'b11, 2'b01);
    cycle();

    clk_run = 1'b0;
    for (int i = 0; i < 11; i++) begin
      in_valid = tbl[i].iv; in_lane_vld = tbl[i].lv;
      in_rj = {tbl[i].rj1, tbl[i].rj0}; in_rk = {tbl[i].rk1, tbl[i].rk0};
      flush = tbl[i].fl; ex_ready = tbl[i].exr; fwd_stall = tbl[i].fst;
      #1;
      chk($sformatf("tbl%0d_hazard", i), hazard_stall, tbl[i].haz);
      chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].rdy);
      check_comb();
    end
    idle(1'b0);
    clk_run = 1'b1;
    @(negedge clk);

    // Asynchronous reset while a bundle is held.
    cycle();
    areset = 1'b1;
    #1;
    model_reset();
    check_regs();
    @(negedge clk);
    areset = 1'b0;
    idle(1'b1);
    set_bundle(2'b01, 5'd1, 5'd2, 5'd5, 5'd0, 5'd0, 5'd0, 2'b01, 2'b00);
    cycle();
    chk("rst_then_out_valid", out_valid, 1'b1);
    chk("rst_then_out_rd0", out_rd[4:0], 5'd5);

    // Back-to-back bundles.
    for (int k = 0; k < 3; k++) begin
      set_bundle(2'b11, 5'd20, 5'd21, 5'(10 + k), 5'd22, 5'd23, 5'd0, 2'b01, 2'b00);
      #1;
      chk("b2b_in_ready", in_ready, 1'b1);
      cycle();
      chk("b2b_out_valid", out_valid, 1'b1);
      chk("b2b_out_rd0", out_rd[4:0], 5'(10 + k));
    end

    // Hold with a lane1 rj forward.
    idle(1'b0);
    rand_data();
    fwd_j_vld = 2'b10;
    fwd_j_data[63:32] = 32'hDEADBEEF;
    cycle();
    chk("fwd_j_lane1", out_rj_data[63:32], 32'hDEADBEEF);
    fwd_j_vld = '0;

    // Load-use interlock: consumer waits out stage + LOAD_LAT scoreboard rows.
    idle(1'b1);
    set_bundle(2'b11, 5'd1, 5'd2, 5'd7, 5'd1, 5'd2, 5'd0, 2'b01, 2'b01);
    cycle();
    set_bundle(2'b11, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b00, 2'b00);
    stalls = 0;
    accepted = 1'b0;
    for (int i = 0; i < 8 && !accepted; i++) begin
      #1;
      if (in_ready) accepted = 1'b1;
      else stalls++;
      cycle();
    end
    chk("loaduse_accepted", accepted, 1'b1);
    chk("loaduse_stall_cycles", stalls, 3);

    // Load targeting r0 never interlocks.
    set_bundle(2'b01, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 2'b01);
    cycle();
    set_bundle(2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00);
    #1;
    chk("r0_no_hazard", hazard_stall, 1'b0);
    cycle();

    // Flush beats issue; the flushed stage's load r9 still blocks a later consumer.
    set_bundle(2'b01, 5'd1, 5'd2, 5'd9, 5'd0, 5'd0, 5'd0, 2'b01, 2'b01);
    cycle();
    set_bundle(2'b01, 5'd9, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 1'b0);
    cycle();
    chk("flush_out_valid", out_valid, 1'b0);
    flush = 1'b0;
    #1;
    chk("flush_sb_hazard", hazard_stall, 1'b1);
    cycle();

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      in_valid = ($urandom % 10) < 7;
      in_lane_vld = 2'($urandom);
      for (int l = 0; l < LANES; l++) begin
        in_rj[l*5 +: 5] = 5'($urandom_range(0, 7));
        in_rk[l*5 +: 5] = 5'($urandom_range(0, 7));
        in_rd[l*5 +: 5] = 5'($urandom_range(0, 7));
      end
      in_we = 2'($urandom); in_is_load = 2'($urandom);
      flush = ($urandom % 16) == 0;
      ex_ready = ($urandom % 4) != 0;
      fwd_stall = ($urandom % 8) == 0;
      fwd_j_vld = 2'($urandom); fwd_k_vld = 2'($urandom);
      rand_data();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/issue_ex_pipe_reg.md
Name: issue_ex_pipe_reg

Overview:
- Parametrised issue→EX pipeline register for the N-lane in-order core. Successor to the dual-lane fixed register stage.
- Captures the decoded bundle and regfile read data, and patches operands from the forwarding network while held.
- Detects load-use hazards with a configurable-depth load scoreboard and back-pressures issue.
- Sits between the decode/issue stage (with the external write-first regfile) and EX.

Parameters:
LANES, 2, issue lanes per bundle
XLEN, 32, operand data width
PW, 160, opaque per-lane payload width (pc, inst, uop, imm, excp fields packed upstream)
LOAD_LAT, 2, extra stage advances after leaving this stage before load data is forwardable (scoreboard depth)

Ports:
clk  in  1  clock
areset  in  1  asynchronous active-high reset
flush  in  1  kill bundle held in this stage
in_valid  in  1  issue bundle valid
in_ready  out  1  stage accepts bundle
in_lane_vld  in  LANES  per-lane valid
in_payload  in  LANES*PW  per-lane payload
in_rj, in_rk, in_rd  in  LANES*5 each  register indices
in_we  in  LANES  lane writes rd
in_is_load  in  LANES  lane is a load
rf_rj_data, rf_rk_data  in  LANES*XLEN each  regfile read data for in_rj/in_rk
fwd_j_vld, fwd_k_vld  in  LANES each  forward hit per operand
fwd_j_data, fwd_k_data  in  LANES*XLEN each  forward data
fwd_stall  in  1  forwarding unit requests hold
ex_ready  in  1  EX can accept
out_valid  out  1  bundle valid to EX
out_lane_vld  out  LANES
out_payload  out  LANES*PW
out_rj_data, out_rk_data  out  LANES*XLEN each
out_rd  out  LANES*5
out_we, out_is_load  out  LANES each
hazard_stall  out  1  load-use interlock active

Behaviour:
- Reset (async, areset=1): out_valid, out_lane_vld, out_payload, out_*_data, out_rd, out_we, out_is_load and all scoreboard entries = 0.
- adv = ex_ready & ~fwd_stall. Stage advances on adv regardless of out_valid; this prevents deadlock on bubbles.
- in_ready = adv & ~hazard_stall & ~flush (combinational).
- Register update priority:
  1. flush: out_valid, out_lane_vld ← 0.
  2. in_valid & in_ready: load all in_* fields and rf data; out_valid ← 1. Latency 1 cycle.
  3. adv without load: out_valid, out_lane_vld ← 0 (bubble).
  4. Hold otherwise. Per lane/operand, fwd_x_vld=1 overwrites the held data with fwd_x_data. All other fields are unchanged.
- Forward patching applies only in the hold case. On the load cycle, rf data is taken unchanged.
- Scoreboard: LOAD_LAT rows × LANES entries of {vld, rd}.
  - On adv: row0 ← per lane {out_valid & out_lane_vld & out_is_load & out_we & (out_rd≠0), out_rd}; row i ← row i-1; oldest row dropped.
  - Flush does not clear the scoreboard; those loads are older and still in flight.
- hazard_stall = 1 iff some in lane l with in_valid & in_lane_vld[l] has a nonzero in_rj or in_rk equal to the rd of:
  - the current stage, for any lane with out_valid & out_lane_vld & out_is_load & out_we; or
  - any valid scoreboard entry.
- r0 never matches.
- Intra-bundle dependencies are excluded by the decoder and are not checked here.
- Simultaneous flush and in_valid: the bundle is not accepted (in_ready=0).
- Simultaneous fwd_stall and flush: flush still clears out_valid.

Test Plan:
- Reset: assert areset mid-hold → all outputs 0 immediately (asynchronously); release, in_valid=1, rd=5, ex_ready=1 → next cycle out_valid=1, out_rd[0]=5.
- Back-to-back: 3 bundles, ex_ready=1 → each appears 1 cycle later; in_ready stays 1; no bubbles.
- Hold + forward: ex_ready=0 with bundle held, fwd_j_vld[1]=1, data 0xDEADBEEF → out_rj_data lane1 = 0xDEADBEEF next cycle; other operands unchanged; payload unchanged.
- Load-use, LOAD_LAT=2: lane0 load rd=7 in stage; next bundle lane1 rj=7 → hazard_stall=1 and in_ready=0 for 3 adv cycles (stage, row0, row1), then accepted on the 4th.
- r0 and lane-mask checks: load with rd=0, or consumer lane with in_lane_vld=0 → hazard_stall=0.
- Flush: flush=1 with in_valid=1 → out_valid=0 next cycle, bundle not accepted. A previously pushed scoreboard rd=9 still stalls a consumer of r9.
